load_store_unit: RTL and testbench

- Memory-stage initiator that turns load/store ops from the execute/memory pipeline register into valid/ready word requests to a data memory that has variable latency.
- Generates byte enables and lane-replicated write data.
- Aligns and sign/zero-extends load data.
- Stalls the pipeline while a request is in flight, and returns a registered writeback result or an error pulse.

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator: valid/ready word requests, 2-edge store / 3-edge load at zero wait.
// Stalls the pipeline until the request and any response complete; errors retire in one DONE cycle.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  stall,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    output logic [3:0]            mem_req_be,
    output logic [31:0]           mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  misalign_err,
    output logic                  illegal_err,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [4:0]            r_rd;
    logic [2:0]            r_funct3;
    logic                  r_is_load;

    logic                  w_start;
    logic                  w_illegal;
    logic                  w_misalign;
    logic                  w_fault;
    logic [7:0]            w_cnt_inc;
    logic                  w_timeout;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;

    assign w_start    = in_valid & (in_load | in_store);
    assign w_illegal  = (in_load & in_store)
                      | (in_load & ((in_funct3 == 3'b011) | (in_funct3 == 3'b110) | (in_funct3 == 3'b111)))
                      | (in_store & (in_funct3[2] | (in_funct3[1:0] == 2'b11)));
    assign w_misalign = ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00))
                      | ((in_funct3[1:0] == 2'b01) & in_addr[0]);
    assign w_fault    = w_illegal | w_misalign;
    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_inc == LP_TIMEOUT);

    // Store lanes come from the byte offset; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_wdata;
        if (in_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << in_addr[1:0];
                    w_wdata = {4{in_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << in_addr[1:0];
                    w_wdata = {2{in_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = in_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rsp_rdata[7:0];
        case (r_addr[1:0])
            2'b00: w_byte = mem_rsp_rdata[7:0];
            2'b01: w_byte = mem_rsp_rdata[15:8];
            2'b10: w_byte = mem_rsp_rdata[23:16];
            2'b11: w_byte = mem_rsp_rdata[31:24];
            default: w_byte = mem_rsp_rdata[7:0];
        endcase
        w_half = r_addr[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        case (r_funct3)
            3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100: w_load_data = {24'd0, w_byte};
            3'b001: w_load_data = {{16{w_half[15]}}, w_half};
            3'b101: w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    stall        = 1'b1;
                    w_next_state = w_fault ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = r_is_load ? S_WAIT_RSP : S_DONE;
                end
            end
            S_WAIT_RSP: begin
                stall = 1'b1;
                if (mem_rsp_valid | w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 8'd0;
            r_addr        <= '0;
            r_rd          <= 5'd0;
            r_funct3      <= 3'd0;
            r_is_load     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_be    <= 4'd0;
            mem_req_wdata <= 32'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            misalign_err  <= 1'b0;
            illegal_err   <= 1'b0;
            bus_err       <= 1'b0;
            err_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_fault) begin
                            illegal_err  <= w_illegal;
                            misalign_err <= ~w_illegal & w_misalign;
                            err_addr     <= in_addr;
                        end else begin
                            r_addr        <= in_addr;
                            r_rd          <= in_rd;
                            r_funct3      <= in_funct3;
                            r_is_load     <= in_load;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= in_store;
                            mem_req_addr  <= in_addr[ADDR_WIDTH-1:2];
                            mem_req_be    <= w_be;
                            mem_req_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_cnt         <= 8'd0;
                    end
                end
                S_WAIT_RSP: begin
                    r_cnt <= w_cnt_inc;
                    // A response on the timeout cycle still wins over the abort.
                    if (mem_rsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_data  <= w_load_data;
                    end else if (w_timeout) begin
                        bus_err  <= 1'b1;
                        err_addr <= r_addr;
                    end
                end
                S_DONE: begin
                    r_cnt        <= 8'd0;
                    wb_valid     <= 1'b0;
                    misalign_err <= 1'b0;
                    illegal_err  <= 1'b0;
                    bus_err      <= 1'b0;
                    err_addr     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: requests and results are queued at drive time and
// matched when the DUT issues a request handshake or a result/error pulse.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    localparam int K_WB    = 0;
    localparam int K_STORE = 1;
    localparam int K_MIS   = 2;
    localparam int K_ILL   = 3;
    localparam int K_BUS   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_load, in_store;
    logic [2:0]    in_funct3;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_wdata;
    logic [4:0]    in_rd;
    logic          stall;
    logic          mem_req_valid, mem_req_we;
    logic [AW-3:0] mem_req_addr;
    logic [3:0]    mem_req_be;
    logic [31:0]   mem_req_wdata;
    logic          mem_req_ready, mem_rsp_valid;
    logic [31:0]   mem_rsp_rdata;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          misalign_err, illegal_err, bus_err;
    logic [AW-1:0] err_addr;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .illegal_err(illegal_err), .bus_err(bus_err),
        .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result/error pulse monitor
    always @(negedge clk) begin
        if (wb_valid | misalign_err | illegal_err | bus_err) begin
            res_t r;
            int   got_kind;
            chk("pulse_onehot", 32'($countones({wb_valid, misalign_err, illegal_err, bus_err})), 1);
            got_kind = wb_valid ? K_WB : misalign_err ? K_MIS : illegal_err ? K_ILL : K_BUS;
            chk("res_pending", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
                r = res_q.pop_front();
                chk("res_kind", 32'(got_kind), 32'(r.kind));
                if (r.kind == K_WB) begin
                    chk("wb_rd", 32'(wb_rd), 32'(r.rd));
                    chk("wb_data", wb_data, r.val);
                end else begin
                    chk("err_addr", err_addr, r.val);
                end
            end
        end
    end

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                          input int kind, input logic [3:0] be, input logic [31:0] exp_val,
                          input int exp_stall);
        req_t q;
        res_t r;
        int   nst = 0, rq = 0, wt = 0, c = 0;
        bit   hs = 0, done = 0;
        if (kind == K_WB || kind == K_STORE || kind == K_BUS) begin
            q.we = st; q.addr = addr[31:2]; q.be = be; q.wdata = exp_val;
            req_q.push_back(q);
        end
        if (kind != K_STORE) begin
            r.kind = kind; r.rd = rd; r.val = exp_val;
            res_q.push_back(r);
        end
        @(negedge clk);
        in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        while (!done && c < 40) begin
            #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (hs) begin
                wt++;
                if (wt == rsp_dly) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rdata;
                end
            end
            if (mem_req_valid) begin
                chk("req_pending", 32'(req_q.size() != 0), 1);
                if (req_q.size() != 0) begin
                    chk("req_we", 32'(mem_req_we), 32'(req_q[0].we));
                    chk("req_addr", 32'(mem_req_addr), 32'(req_q[0].addr));
                    chk("req_be", 32'(mem_req_be), 32'(req_q[0].be));
                    if (req_q[0].we) chk("req_wdata", mem_req_wdata, req_q[0].wdata);
                    mem_req_ready = (rq >= rdy_dly);
                    rq++;
                    if (mem_req_ready) begin
                        void'(req_q.pop_front());
                        hs = 1;
                    end
                end
            end
            if (stall) nst++;
            else done = 1;
            c++;
            if (!done) @(negedge clk);
        end
        chk("op_completed", 32'(done), 1);
        chk("stall_cycles", 32'(nst), 32'(exp_stall));
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_wait;
        rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
        in_addr = '0; in_wdata = '0; in_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'({stall, mem_req_valid, mem_req_we, wb_valid, misalign_err, illegal_err, bus_err}), 0);
        chk("rst_be", 32'(mem_req_be), 0);
        chk("rst_wdata", mem_req_wdata, 0);
        chk("rst_err_addr", err_addr, 0);
        rst = 1'b0;

        // ld st f3 addr wdata rd rdata rdy rsp kind be expected stall
        run_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, K_STORE, 4'b1111, 32'hDEADBEEF, 2);
        run_op(0, 1, 3'b000, 32'h13, 32'h000000A5, 0, 0, 0, 0, K_STORE, 4'b1000, 32'hA5A5A5A5, 2);
        run_op(0, 1, 3'b001, 32'h12, 32'h00001234, 0, 0, 0, 0, K_STORE, 4'b1100, 32'h12341234, 2);
        run_op(0, 1, 3'b000, 32'h40, 32'h123456EF, 0, 0, 2, 1, K_STORE, 4'b0001, 32'hEFEFEFEF, 4);
        run_op(1, 0, 3'b000, 32'h21, 0, 5'd5, 32'h00008000, 0, 1, K_WB, 4'b1111, 32'hFFFFFF80, 3);
        run_op(1, 0, 3'b100, 32'h21, 0, 5'd6, 32'h00008000, 0, 1, K_WB, 4'b1111, 32'h00000080, 3);
        run_op(1, 0, 3'b001, 32'h22, 0, 5'd7, 32'h80010000, 0, 1, K_WB, 4'b1111, 32'hFFFF8001, 3);
        run_op(1, 0, 3'b101, 32'h22, 0, 5'd8, 32'h80010000, 0, 1, K_WB, 4'b1111, 32'h00008001, 3);
        run_op(1, 0, 3'b000, 32'h43, 0, 5'd9, 32'h7F000000, 0, 1, K_WB, 4'b1111, 32'h0000007F, 3);
        run_op(1, 0, 3'b001, 32'h20, 0, 5'd10, 32'h0000ABCD, 0, 1, K_WB, 4'b1111, 32'hFFFFABCD, 3);
        run_op(1, 0, 3'b010, 32'h24, 0, 5'd11, 32'h12345678, 3, 3, K_WB, 4'b1111, 32'h12345678, 8);
        run_op(1, 0, 3'b010, 32'h28, 0, 5'd12, 32'hCAFEF00D, 0, TO, K_WB, 4'b1111, 32'hCAFEF00D, 2 + TO);
        run_op(1, 0, 3'b010, 32'h06, 0, 5'd13, 0, 0, 0, K_MIS, 4'b0000, 32'h00000006, 1);
        run_op(1, 0, 3'b001, 32'h23, 0, 5'd14, 0, 0, 0, K_MIS, 4'b0000, 32'h00000023, 1);
        run_op(0, 1, 3'b001, 32'h11, 32'h55, 0, 0, 0, 0, K_MIS, 4'b0000, 32'h00000011, 1);
        run_op(1, 1, 3'b010, 32'h08, 0, 5'd15, 0, 0, 0, K_ILL, 4'b0000, 32'h00000008, 1);
        run_op(1, 0, 3'b011, 32'h0C, 0, 5'd16, 0, 0, 0, K_ILL, 4'b0000, 32'h0000000C, 1);
        run_op(0, 1, 3'b100, 32'h05, 0, 5'd17, 0, 0, 0, K_ILL, 4'b0000, 32'h00000005, 1);
        run_op(1, 0, 3'b010, 32'h30, 0, 5'd18, 0, 0, 0, K_BUS, 4'b1111, 32'h00000030, 2 + TO);

        // Reset while waiting for a response, then a late response must be dropped.
        q_push_load();
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h50; in_rd = 5'd19;
        hs_wait = 0;
        while (hs_wait < 10 && !mem_req_valid) begin
            @(negedge clk);
            hs_wait++;
        end
        chk("rstmid_req_seen", 32'(mem_req_valid), 1);
        #1 mem_req_ready = 1'b1;
        void'(req_q.pop_front());
        @(negedge clk);
        mem_req_ready = 1'b0;
        in_valid = 1'b0; in_load = 1'b0;
        @(negedge clk);
        chk("rstmid_stall_wait", 32'(stall), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11112222;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_flags", 32'({stall, mem_req_valid, mem_req_we, wb_valid, misalign_err, illegal_err, bus_err}), 0);
        chk("rstmid_wb_data", wb_data, 0);
        chk("rstmid_wb_rd", 32'(wb_rd), 0);
        chk("rstmid_req_addr", 32'(mem_req_addr), 0);
        chk("rstmid_err_addr", err_addr, 0);

        run_op(1, 0, 3'b010, 32'h54, 0, 5'd20, 32'h0BADCAFE, 0, 1, K_WB, 4'b1111, 32'h0BADCAFE, 3);

        repeat (3) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 0);
        chk("res_q_drained", 32'(res_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic q_push_load();
        req_t q;
        q.we = 1'b0; q.addr = 30'h14; q.be = 4'b1111; q.wdata = 32'd0;
        req_q.push_back(q);
    endtask

endmodule
